// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive safety, order and timing checker for a 4-way light controller
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 16,
    parameter int YELLOW_CYCLES = 4,
    parameter int LAP_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       north_light,
    input  logic [2:0]       west_light,
    input  logic [2:0]       south_light,
    input  logic [2:0]       east_light,
    output logic [1:0]       active_dir,
    output logic             active_yellow,
    output logic             lap_done,
    output logic [LAP_W-1:0] lap_count,
    output logic             fault,
    output logic [2:0]       fault_code
);
    localparam int MAX_CYCLES = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    // One spare bit so the run counter can reach the full duration without wrapping.
    localparam int RUN_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [RUN_W-1:0] GREEN_RUN  = RUN_W'(GREEN_CYCLES);
    localparam logic [RUN_W-1:0] YELLOW_RUN = RUN_W'(YELLOW_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_ALL_RED  = 3'd3;
    localparam logic [2:0] CODE_ORDER    = 3'd4;
    localparam logic [2:0] CODE_SHORT    = 3'd5;
    localparam logic [2:0] CODE_LONG     = 3'd6;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    state_t           state, state_n;
    logic [2:0]       phase, phase_n;
    logic [RUN_W-1:0] run, run_n;
    logic             partial, partial_n;
    logic [1:0]       dir_n;
    logic             yellow_n;
    logic             lap_done_n;
    logic [LAP_W-1:0] lap_count_n;
    logic             fault_n;
    logic [2:0]       fault_code_n;

    // Index 0 is north so the loop index is the direction code directly.
    logic [3:0][2:0]  buses;
    logic             bus_illegal;
    logic [2:0]       non_red;
    logic [1:0]       sample_dir;
    logic             sample_yellow;
    logic [2:0]       decode_code;
    logic [2:0]       check_code;
    logic [2:0]       sample_phase;
    logic [2:0]       successor;
    logic [RUN_W-1:0] duration;

    assign buses        = {east_light, south_light, west_light, north_light};
    assign sample_phase = {sample_dir, sample_yellow};
    assign successor    = phase + 3'd1;
    assign duration     = phase[0] ? YELLOW_RUN : GREEN_RUN;

    // Decode one sample into its phase and the bus-level violation it carries, if any.
    always_comb begin
        bus_illegal   = 1'b0;
        non_red       = 3'd0;
        sample_dir    = 2'd0;
        sample_yellow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (buses[i] != LIGHT_GREEN && buses[i] != LIGHT_YELLOW && buses[i] != LIGHT_RED)
                bus_illegal = 1'b1;
            if (buses[i] != LIGHT_RED) begin
                non_red       = non_red + 3'd1;
                sample_dir    = 2'(i);
                sample_yellow = (buses[i] == LIGHT_YELLOW);
            end
        end
        if (bus_illegal)
            decode_code = CODE_ILLEGAL;
        else if (non_red >= 3'd2)
            decode_code = CODE_CONFLICT;
        else if (non_red == 3'd0)
            decode_code = CODE_ALL_RED;
        else
            decode_code = CODE_NONE;
    end

    // Add the sequence checks, which only have meaning once a phase is being tracked.
    always_comb begin
        check_code = decode_code;
        if (decode_code == CODE_NONE && state == TRACK) begin
            if (sample_phase == phase) begin
                if (run >= duration)
                    check_code = CODE_LONG;
            end else if (sample_phase != successor) begin
                check_code = CODE_ORDER;
            end else if (!partial && run < duration) begin
                check_code = CODE_SHORT;
            end
        end
    end

    // Next-state and next-output logic; FAULT holds everything except the lap pulse.
    always_comb begin
        state_n      = state;
        phase_n      = phase;
        run_n        = run;
        partial_n    = partial;
        dir_n        = active_dir;
        yellow_n     = active_yellow;
        lap_done_n   = 1'b0;
        lap_count_n  = lap_count;
        fault_n      = fault;
        fault_code_n = fault_code;
        case (state)
            SYNC, TRACK: begin
                if (check_code != CODE_NONE) begin
                    state_n      = FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = check_code;
                end else if (state == TRACK && sample_phase == phase) begin
                    run_n = run + RUN_ONE;
                end else begin
                    state_n   = TRACK;
                    phase_n   = sample_phase;
                    run_n     = RUN_ONE;
                    partial_n = (state == SYNC);
                    dir_n     = sample_dir;
                    yellow_n  = sample_yellow;
                    if (state == TRACK && phase == 3'd7) begin
                        lap_done_n  = 1'b1;
                        lap_count_n = lap_count + LAP_W'(1);
                    end
                end
            end
            FAULT: begin
            end
            default: state_n = SYNC;
        endcase
    end

    // State and output registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SYNC;
            phase         <= 3'd0;
            run           <= '0;
            partial       <= 1'b0;
            active_dir    <= 2'd0;
            active_yellow <= 1'b0;
            lap_done      <= 1'b0;
            lap_count     <= '0;
            fault         <= 1'b0;
            fault_code    <= CODE_NONE;
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            run           <= run_n;
            partial       <= partial_n;
            active_dir    <= dir_n;
            active_yellow <= yellow_n;
            lap_done      <= lap_done_n;
            lap_count     <= lap_count_n;
            fault         <= fault_n;
            fault_code    <= fault_code_n;
        end
    end
endmodule
